link_burst_top: RTL
===================

# link_burst_top

Parametrised successor to the fixed 4-byte master/slave link. A master FSM and a slave FSM are connected by a 4-phase req/ack handshake and carry a runtime-selectable burst of DATA_W-bit words. The slave can be configured to delay its acknowledge by a fixed number of cycles. The slave accumulates a checksum and reports completion with a single-cycle done pulse. The block is self-contained and sits at the top of the link sub-design, driven directly by the bench.

## Interface

Parameters:
- DATA_W, 8: word width in bits.
- MAX_LEN, 15: maximum burst length in words. LEN_W = $clog2(MAX_LEN+1).
- SEED, 8'hA0: value of word 0 of every burst. Truncated to DATA_W.
- STEP, 1: increment between consecutive words.
- ACK_DELAY, 0: extra cycles the slave waits between latching a word and raising ack.

Ports:
- clk, input, 1: the single clock; all logic on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: burst request. Sampled only while idle.
- len, input, LEN_W: burst length. Captured when start is accepted; values above MAX_LEN clamp to MAX_LEN.
- busy, output, 1: high from the accepted start until done.
- done, output, 1: one-cycle completion pulse.
- req, output, 1: master-to-slave handshake, exposed for debug.
- ack, output, 1: slave-to-master handshake, exposed for debug.
- data, output, DATA_W: master data bus.
- last_word, output, DATA_W: last word latched by the slave.
- word_count, output, LEN_W: words received in the current or last burst.
- checksum, output, DATA_W: sum of received words, mod 2^DATA_W.

## Operation

- All outputs reset to 0. Reset sends both FSMs to idle and clears the index, the delay counter and all accumulators.
- Word k of a burst = SEED + k·STEP, mod 2^DATA_W. Wrap-around is silent.
- Master FSM states: M_IDLE, M_REQ, M_WAIT_ACK_LOW.
  - M_IDLE with start=1 and captured len=0: done<=1 for one cycle. No req is raised. checksum and word_count are cleared.
  - M_IDLE with start=1 and len>0: clear checksum and word_count, index<=0, data<=SEED, req<=1, busy<=1, go to M_REQ.
  - M_REQ with ack=1: req<=0, go to M_WAIT_ACK_LOW.
  - M_WAIT_ACK_LOW with ack=0:
    - If index==len-1: busy<=0, done<=1, go to M_IDLE.
    - Otherwise: index++, data<=next word, req<=1, go to M_REQ.
- Slave FSM states: S_IDLE, S_DELAY, S_ACK.
  - S_IDLE with req=1: last_word<=data, checksum+=data, word_count++.
    - If ACK_DELAY==0: ack<=1, go to S_ACK.
    - Otherwise: load the delay counter, go to S_DELAY.
  - S_DELAY: count ACK_DELAY cycles, then ack<=1 and go to S_ACK.
  - S_ACK with req=0: ack<=0, go to S_IDLE.
- start while busy is ignored. len changes during a burst have no effect.
- Reset mid-burst aborts immediately. No done is issued, and partial results are cleared.

## Timing

- All outputs are registered. Let E0 be the clock edge at which start is accepted.
- Word k:
  - req rises after edge E0 + k·(4+ACK_DELAY).
  - ack rises (1+ACK_DELAY) edges after req rises.
  - req falls 1 edge after ack rises.
  - ack falls 1 edge after req falls.
- Per-word cost is 4+ACK_DELAY cycles.
- done is high for exactly the cycle following edge E0 + L·(4+ACK_DELAY). busy falls at that same edge.
- A new start is accepted as early as the cycle in which done is high; its first req rises at the next edge.
- len=0: done is high for the cycle after E0 + 1. busy never rises.
- checksum, word_count and last_word are stable once done is high and hold until the next accepted start or reset.

## Test plan

- Reset: hold rst high for 2 cycles with start=1 -> every output stays 0; nothing happens until after rst falls.
- Defaults, len=4, one start pulse -> data on the four req rises is A0, A1, A2, A3; done high for exactly one cycle after edge E0+16; checksum=0x86, word_count=4, last_word=0xA3.
- len=0 -> done pulse after edge E0+1; req never asserted; checksum=0, word_count=0.
- Wrap-around: SEED=8'hFE, len=4 -> words FE, FF, 00, 01; checksum=0xFE; last_word=0x01.
- ACK_DELAY=2, len=3, extra start pulse while busy -> each ack rises 3 edges after its req; done after edge E0+18; the second start is ignored (only one done).
- Reset after the second ack falls (len=4) -> req, ack and busy are 0 the next cycle; no done; a following start with len=4 completes a full fresh burst, checksum=0x86.

Source files
------------

// File: rtl/link_burst_top.sv
// rtl/link_burst_top.sv - master/slave req/ack burst link with checksum and done pulse
module link_burst_top #(
    parameter int DATA_W    = 8,
    parameter int MAX_LEN   = 15,
    parameter int SEED      = 'hA0,
    parameter int STEP      = 1,
    parameter int ACK_DELAY = 0,
    localparam int LEN_W    = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              req,
    output logic              ack,
    output logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] last_word,
    output logic [LEN_W-1:0]  word_count,
    output logic [DATA_W-1:0] checksum
);
    localparam int DLY_W = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;
    localparam logic [DATA_W-1:0] SEED_W    = DATA_W'(SEED);
    localparam logic [DATA_W-1:0] STEP_W    = DATA_W'(STEP);
    localparam logic [LEN_W-1:0]  MAX_LEN_W = LEN_W'(MAX_LEN);
    localparam logic [DLY_W-1:0]  DLY_LOAD  = DLY_W'(ACK_DELAY - 1);

    typedef enum logic [1:0] {M_IDLE, M_REQ, M_WAIT_ACK_LOW} m_state_t;
    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_ACK} s_state_t;

    m_state_t m_state, m_next;
    s_state_t s_state, s_next;

    logic [LEN_W-1:0] len_eff;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] idx;
    logic [DLY_W-1:0] dly;
    logic             zero_pend;
    logic             accept;
    logic             launch;
    logic             zero_hit;
    logic             step;
    logic             finish;
    logic             at_last;

    assign len_eff = (len > MAX_LEN_W) ? MAX_LEN_W : len;
    assign at_last = (idx == len_q - LEN_W'(1));

    // A zero-length start holds off further starts for one cycle so done lands one edge later.
    always_comb begin
        m_next   = m_state;
        accept   = 1'b0;
        launch   = 1'b0;
        zero_hit = 1'b0;
        step     = 1'b0;
        finish   = 1'b0;
        case (m_state)
            M_IDLE: begin
                accept   = start && !zero_pend;
                launch   = accept && (len_eff != '0);
                zero_hit = accept && (len_eff == '0);
                if (launch) m_next = M_REQ;
            end
            M_REQ: begin
                if (ack) m_next = M_WAIT_ACK_LOW;
            end
            M_WAIT_ACK_LOW: begin
                if (!ack) begin
                    finish = at_last;
                    step   = !at_last;
                    m_next = at_last ? M_IDLE : M_REQ;
                end
            end
            default: m_next = M_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_state   <= M_IDLE;
            req       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            data      <= '0;
            idx       <= '0;
            len_q     <= '0;
            zero_pend <= 1'b0;
        end else begin
            m_state   <= m_next;
            done      <= zero_pend || finish;
            zero_pend <= zero_hit;
            if (launch) begin
                len_q <= len_eff;
                idx   <= '0;
                data  <= SEED_W;
                req   <= 1'b1;
                busy  <= 1'b1;
            end
            if (m_state == M_REQ && ack) req <= 1'b0;
            if (step) begin
                idx  <= idx + LEN_W'(1);
                data <= data + STEP_W;
                req  <= 1'b1;
            end
            if (finish) busy <= 1'b0;
        end
    end

    always_comb begin
        s_next = s_state;
        case (s_state)
            S_IDLE:  if (req) s_next = (ACK_DELAY == 0) ? S_ACK : S_DELAY;
            S_DELAY: if (dly == '0) s_next = S_ACK;
            S_ACK:   if (!req) s_next = S_IDLE;
            default: s_next = S_IDLE;
        endcase
    end

    // Accumulators are cleared on any accepted start; req is always low then, so no latch collides.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_state    <= S_IDLE;
            ack        <= 1'b0;
            dly        <= '0;
            last_word  <= '0;
            word_count <= '0;
            checksum   <= '0;
        end else begin
            s_state <= s_next;
            if (accept) begin
                checksum   <= '0;
                word_count <= '0;
            end else if (s_state == S_IDLE && req) begin
                last_word  <= data;
                checksum   <= checksum + data;
                word_count <= word_count + LEN_W'(1);
                if (ACK_DELAY == 0) ack <= 1'b1;
                else                dly <= DLY_LOAD;
            end
            if (s_state == S_DELAY) begin
                if (dly == '0) ack <= 1'b1;
                else           dly <= dly - DLY_W'(1);
            end
            if (s_state == S_ACK && !req) ack <= 1'b0;
        end
    end
endmodule
